md_unit: RTL and testbench

Multiply/divide unit for the E stage. Consumes the `start`, `MDOP`, `MDWE` and `AOOP` controls produced by the E-stage controller, computes the 64-bit HI/LO result over a fixed multi-cycle latency, and returns the remaining-cycle count `tim`. The controller uses `tim` to derive `busy` and to gate the next `start`. The block also provides the HI/LO read-out for mfhi/mflo and the write path for mthi/mtlo.

---
 rtl/md_unit.sv | 97 +++++++++
 tb/tb_md_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, mthi/mtlo writes and mfhi/mflo read-out.
// Optional build macro MD_DIV0_HOLD_EN: a divide by zero leaves HI/LO untouched at commit.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  MDOP,
    input  logic [1:0]  MDWE,
    input  logic [1:0]  AOOP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [4:0]  tim,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    logic [31:0] phi, plo;
    logic [63:0] prod_s, prod_u, res;
    logic        neg_a, neg_b, div0;
    logic [31:0] ua, ub, ubs, uq, ur, q, r;

`ifdef MD_DIV0_HOLD_EN
    logic phold;
`endif

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps cleanly
    // to 0x80000000 with remainder 0.
    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};
        neg_a  = MDOP[1] & A[31];
        neg_b  = MDOP[1] & B[31];
        ua     = neg_a ? (~A + 32'd1) : A;
        ub     = neg_b ? (~B + 32'd1) : B;
        div0   = (B == 32'd0);
        ubs    = div0 ? 32'd1 : ub;
        uq     = ua / ubs;
        ur     = ua % ubs;
        q      = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        r      = neg_a ? (~ur + 32'd1) : ur;
        res    = 64'd0;
        if (!MDOP[0])
            res = MDOP[1] ? prod_s : prod_u;
        else if (div0)
            res = {A, 32'hFFFF_FFFF};
        else
            res = {r, q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tim <= 5'd0;
            HI  <= 32'd0;
            LO  <= 32'd0;
            phi <= 32'd0;
            plo <= 32'd0;
`ifdef MD_DIV0_HOLD_EN
            phold <= 1'b0;
`endif
        end else if (tim == 5'd0) begin
            if (start) begin
                phi <= res[63:32];
                plo <= res[31:0];
                tim <= MDOP[0] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
`ifdef MD_DIV0_HOLD_EN
                phold <= MDOP[0] & div0;
`endif
            end else begin
                if (MDWE[0]) HI <= A;
                if (MDWE[1]) LO <= A;
            end
        end else begin
            tim <= tim - 5'd1;
`ifdef MD_DIV0_HOLD_EN
            if (tim == 5'd1 && !phold) begin
`else
            if (tim == 5'd1) begin
`endif
                HI <= phi;
                LO <= plo;
            end
        end
    end

    always_comb begin
        case (AOOP)
            2'b01, 2'b11: MDout = HI;
            2'b10:        MDout = LO;
            default:      MDout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, arithmetic, register writes, reset.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  MDOP, MDWE, AOOP;
    logic [31:0] A, B;
    logic [4:0]  tim;
    logic [31:0] HI, LO, MDout;

    int npass = 0;
    int ntotal = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDOP(MDOP), .MDWE(MDWE),
        .AOOP(AOOP), .A(A), .B(B), .tim(tim), .HI(HI), .LO(LO), .MDout(MDout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        MDOP = op; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; MDOP = 2'b00; MDWE = 2'b00; AOOP = 2'b01;
        A = 32'h0; B = 32'h0;
        tick(2);
        ntotal++; if (tim !== 5'd0) $display("FAIL reset_tim: got %0d expected 0", tim); else npass++;
        ntotal++; if (HI !== 32'h0) $display("FAIL reset_hi: got %h expected 0", HI); else npass++;
        ntotal++; if (LO !== 32'h0) $display("FAIL reset_lo: got %h expected 0", LO); else npass++;
        ntotal++; if (MDout !== 32'h0) $display("FAIL reset_mdout: got %h expected 0", MDout); else npass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult;
        launch(2'b10, 32'hFFFF_FFFE, 32'd3);
        for (int k = 5; k >= 1; k--) begin
            ntotal++; if (tim !== 5'(k)) $display("FAIL mult_tim: got %0d expected %0d", tim, k); else npass++;
            ntotal++; if (HI !== 32'h0 || LO !== 32'h0)
                $display("FAIL mult_early: got %h_%h expected 0_0", HI, LO); else npass++;
            tick();
        end
        ntotal++; if (tim !== 5'd0) $display("FAIL mult_tim_end: got %0d expected 0", tim); else npass++;
        ntotal++; if (HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", HI); else npass++;
        ntotal++; if (LO !== 32'hFFFF_FFFA) $display("FAIL mult_lo: got %h expected fffffffa", LO); else npass++;
    endtask

    task automatic test_div_restart;
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        ntotal++; if (tim !== 5'd10) $display("FAIL div_tim_load: got %0d expected 10", tim); else npass++;
        tick(6);
        ntotal++; if (tim !== 5'd4) $display("FAIL div_tim_mid: got %0d expected 4", tim); else npass++;
        launch(2'b00, 32'd5, 32'd7);
        ntotal++; if (tim !== 5'd3) $display("FAIL div_restart_tim: got %0d expected 3", tim); else npass++;
        tick(3);
        ntotal++; if (LO !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", LO); else npass++;
        ntotal++; if (HI !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", HI); else npass++;
    endtask

    task automatic test_divu;
        launch(2'b01, 32'hFFFF_FFF9, 32'd2);
        tick(9);
        ntotal++; if (LO === 32'h7FFF_FFFC) $display("FAIL divu_early: got %h one edge before commit", LO); else npass++;
        tick();
        ntotal++; if (LO !== 32'h7FFF_FFFC) $display("FAIL divu_lo: got %h expected 7ffffffc", LO); else npass++;
        ntotal++; if (HI !== 32'h1) $display("FAIL divu_hi: got %h expected 1", HI); else npass++;
    endtask

    // Each start issued in the cycle right after the previous commit.
    task automatic test_back_to_back;
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        tick(10);
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        ntotal++; if (LO !== 32'h8000_0000 || HI !== 32'h0)
            $display("FAIL div_ovf: got %h_%h expected 00000000_80000000", HI, LO); else npass++;
        ntotal++; if (tim !== 5'd5) $display("FAIL b2b_tim: got %0d expected 5", tim); else npass++;
        tick(5);
        ntotal++; if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001)
            $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", HI, LO); else npass++;
    endtask

    task automatic test_div0;
        MDWE = 2'b01; A = 32'hAA; tick();
        MDWE = 2'b10; A = 32'hBB; tick();
        MDWE = 2'b00;
        launch(2'b01, 32'h1234, 32'd0);
        ntotal++; if (tim !== 5'd10) $display("FAIL div0_tim: got %0d expected 10", tim); else npass++;
        tick(10);
`ifdef MD_DIV0_HOLD_EN
        ntotal++; if (HI !== 32'hAA || LO !== 32'hBB)
            $display("FAIL divu0: got %h_%h expected 000000aa_000000bb", HI, LO); else npass++;
`else
        ntotal++; if (HI !== 32'h1234 || LO !== 32'hFFFF_FFFF)
            $display("FAIL divu0: got %h_%h expected 00001234_ffffffff", HI, LO); else npass++;
        launch(2'b11, 32'hFFFF_FFFB, 32'd0);
        tick(10);
        ntotal++; if (HI !== 32'hFFFF_FFFB || LO !== 32'hFFFF_FFFF)
            $display("FAIL div0_signed: got %h_%h expected fffffffb_ffffffff", HI, LO); else npass++;
`endif
    endtask

    task automatic test_regs;
        MDWE = 2'b01; A = 32'h55; tick();
        MDWE = 2'b10; A = 32'h66; tick();
        MDWE = 2'b00;
        AOOP = 2'b01; #1;
        ntotal++; if (MDout !== 32'h55) $display("FAIL mdout_hi: got %h expected 55", MDout); else npass++;
        AOOP = 2'b10; #1;
        ntotal++; if (MDout !== 32'h66) $display("FAIL mdout_lo: got %h expected 66", MDout); else npass++;
        AOOP = 2'b11; #1;
        ntotal++; if (MDout !== 32'h55) $display("FAIL mdout_11: got %h expected 55", MDout); else npass++;
        AOOP = 2'b00; #1;
        ntotal++; if (MDout !== 32'h0) $display("FAIL mdout_00: got %h expected 0", MDout); else npass++;
        AOOP = 2'b01;
        launch(2'b10, 32'd2, 32'd3);
        MDWE = 2'b01; A = 32'h77; tick();
        MDWE = 2'b00;
        ntotal++; if (HI !== 32'h55) $display("FAIL mthi_run: got %h expected 55", HI); else npass++;
        tick(4);
        ntotal++; if (HI !== 32'h0 || LO !== 32'h6)
            $display("FAIL mult_small: got %h_%h expected 0_6", HI, LO); else npass++;
        // Write together with start: start wins, MDWE ignored.
        MDWE = 2'b11; launch(2'b10, 32'h99, 32'd1);
        MDWE = 2'b00;
        ntotal++; if (HI !== 32'h0 || LO !== 32'h6)
            $display("FAIL mdwe_with_start: got %h_%h expected 0_6", HI, LO); else npass++;
        tick(5);
        MDWE = 2'b11; A = 32'hC3; tick();
        MDWE = 2'b00;
        ntotal++; if (HI !== 32'hC3 || LO !== 32'hC3)
            $display("FAIL mdwe_both: got %h_%h expected c3_c3", HI, LO); else npass++;
    endtask

    task automatic test_reset_mid;
        launch(2'b10, 32'hFFFF_FFFE, 32'd3);
        tick(2);
        ntotal++; if (tim !== 5'd3) $display("FAIL rmid_tim_pre: got %0d expected 3", tim); else npass++;
        reset = 1'b1; tick(); reset = 1'b0;
        ntotal++; if (tim !== 5'd0) $display("FAIL rmid_tim: got %0d expected 0", tim); else npass++;
        ntotal++; if (HI !== 32'h0 || LO !== 32'h0)
            $display("FAIL rmid_hilo: got %h_%h expected 0_0", HI, LO); else npass++;
        tick(6);
        ntotal++; if (HI !== 32'h0 || LO !== 32'h0 || tim !== 5'd0)
            $display("FAIL rmid_nocommit: got %h_%h tim %0d expected 0_0 tim 0", HI, LO, tim); else npass++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_restart();
        test_divu();
        test_back_to_back();
        test_div0();
        test_regs();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
